// File: rtl/user_uart_pkg.sv
// user_uart_pkg: shared types and constants for the user_uart_tx block.
package user_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam logic [3:0] REG_TXDATA = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_CLKDIV = 4'h8;

  localparam int unsigned STAT_EMPTY  = 0;
  localparam int unsigned STAT_FULL   = 1;
  localparam int unsigned STAT_BUSY   = 2;
  localparam int unsigned STAT_OVF    = 3;
  localparam int unsigned STAT_LVL_LO = 4;
  localparam int unsigned STAT_LVL_HI = 7;
  localparam int unsigned STAT_PARITY = 8;

  localparam logic [15:0] CLKDIV_MIN = 16'd4;

  // Divisors below the floor would leave too few clocks per bit for the FSM.
  function automatic logic [15:0] clamp_div(input logic [15:0] value);
    return (value < CLKDIV_MIN) ? CLKDIV_MIN : value;
  endfunction

endpackage

// File: rtl/user_uart_tx_if.sv
// user_uart_tx_if: Wishbone slave-side signal bundle for user_uart_tx.
interface user_uart_tx_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8-bit synchronous show-ahead FIFO; a pop frees a slot for a
// same-cycle push even when full.
module uart_tx_fifo #(
  parameter  int unsigned Depth = 8,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  logic [7:0]     wdata_i,
  input  logic           pop_i,
  output logic [7:0]     rdata_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [AddrW:0] level_o
);

  logic [7:0]       mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AddrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AddrW + 1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AddrW + 1)'(1);
    end
  end

endmodule

// File: rtl/user_uart_tx.sv
// user_uart_tx: Wishbone-slave UART transmitter (LSB first) with TX FIFO.
// Define UART_TX_PARITY_EN to insert an even parity bit before the stop bit.
module user_uart_tx
  import user_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_1000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DEF_CLKDIV = 16'd4167
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n,
  user_uart_tx_if.slave wbs,
  output logic          tx_o,
  output logic          tx_busy_o
);

  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam logic ParityEn = 1'b1;
`else
  localparam logic ParityEn = 1'b0;
`endif

  logic            ack_q;
  logic [31:0]     dat_q, rdata;
  logic [15:0]     clkdiv_q, clkdiv_d, clkdiv_wr;
  logic            ovf_q, ovf_d, busy_q;
  logic            hit, wr_en, rd_en, push;
  logic [3:0]      offset;
  logic            pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [LvlW-1:0] fifo_level;
  logic            unused_bits;

  uart_state_e     state_q, state_d;
  logic [15:0]     cnt_q, cnt_d, div_q, div_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      byte_q, byte_d;
  logic            tx_q, tx_d, load, bit_done;

  assign offset = wbs.wbs_adr_i[3:0];
  assign hit    = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q &
                  (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr_en  = hit & wbs.wbs_we_i;
  assign rd_en  = hit & ~wbs.wbs_we_i;
  assign push   = wr_en & (offset == REG_TXDATA) & wbs.wbs_sel_i[0];
  assign unused_bits = ^{wbs.wbs_dat_i[31:16], wbs.wbs_sel_i[3:2]};

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign tx_o          = tx_q;
  assign tx_busy_o     = busy_q;

  uart_tx_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_n),
    .push_i  (push),
    .wdata_i (wbs.wbs_dat_i[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Register writes: CLKDIV byte-lane merge with floor, overflow set/clear.
  always_comb begin
    clkdiv_wr = clkdiv_q;
    if (wbs.wbs_sel_i[0]) clkdiv_wr[7:0]  = wbs.wbs_dat_i[7:0];
    if (wbs.wbs_sel_i[1]) clkdiv_wr[15:8] = wbs.wbs_dat_i[15:8];
    clkdiv_d = clkdiv_q;
    if (wr_en && offset == REG_CLKDIV) clkdiv_d = clamp_div(clkdiv_wr);
    ovf_d = ovf_q;
    if (push && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end else if (wr_en && offset == REG_STATUS && wbs.wbs_sel_i[0] &&
                 wbs.wbs_dat_i[STAT_OVF]) begin
      ovf_d = 1'b0;
    end
  end

  // Read mux; unmapped offsets and TXDATA read as zero.
  always_comb begin
    rdata = '0;
    case (offset)
      REG_STATUS: begin
        rdata[STAT_EMPTY]                = fifo_empty;
        rdata[STAT_FULL]                 = fifo_full;
        rdata[STAT_BUSY]                 = busy_q;
        rdata[STAT_OVF]                  = ovf_q;
        rdata[STAT_LVL_HI:STAT_LVL_LO]   = 4'(fifo_level);
        rdata[STAT_PARITY]               = ParityEn;
      end
      REG_CLKDIV: rdata[15:0] = clkdiv_q;
      default:    rdata = '0;
    endcase
  end

  // Bus response and control registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      clkdiv_q <= DEF_CLKDIV;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ack_q    <= hit;
      dat_q    <= rd_en ? rdata : '0;
      clkdiv_q <= clkdiv_d;
      ovf_q    <= ovf_d;
      busy_q   <= (state_q != StIdle) | ~fifo_empty;
    end
  end

  // FSM state register; tx is registered so the line never glitches.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      div_q   <= DEF_CLKDIV;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      div_q   <= div_d;
      tx_q    <= tx_d;
    end
  end

  // FSM next state and baud counter; load pops the FIFO head into the shifter.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    div_d    = div_q;
    pop      = 1'b0;
    load     = 1'b0;
    bit_done = (cnt_q == '0);
    case (state_q)
      StIdle: load = ~fifo_empty;
      StStart: begin
        if (bit_done) begin
          cnt_d   = div_q - 16'd1;
          state_d = StData;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        if (bit_done) begin
          cnt_d = div_q - 16'd1;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StParity: begin
        if (bit_done) begin
          cnt_d   = div_q - 16'd1;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (bit_done) begin
          if (!fifo_empty) load = 1'b1;
          else state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // Divisor is latched per frame so CLKDIV writes only affect later frames.
    if (load) begin
      pop     = 1'b1;
      byte_d  = fifo_rdata;
      div_d   = clkdiv_q;
      cnt_d   = clkdiv_q - 16'd1;
      idx_d   = '0;
      state_d = StStart;
    end
  end

  // Line level for the upcoming state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = byte_d[idx_d];
      StParity: tx_d = ^byte_d;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_user_uart_tx.sv
// tb_user_uart_tx: directed self-checking bench for user_uart_tx.
module tb_user_uart_tx;

  localparam logic [31:0] A_TX  = 32'h3000_1000;
  localparam logic [31:0] A_ST  = 32'h3000_1004;
  localparam logic [31:0] A_DIV = 32'h3000_1008;
  localparam logic [31:0] A_UNM = 32'h3000_100C;
  localparam logic [31:0] A_OUT = 32'h3000_2004;
`ifdef UART_TX_PARITY_EN
  localparam logic [31:0] PAR = 32'h100;
`else
  localparam logic [31:0] PAR = 32'h0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic        exp_ack;
    logic [31:0] exp_rdat;
  } vec_t;

  logic clk;
  logic wb_rst_n;
  logic tx;
  logic busy;
  int   n_checks;
  int   n_pass;

  user_uart_tx_if bus ();

  user_uart_tx dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (wb_rst_n),
    .wbs       (bus),
    .tx_o      (tx),
    .tx_busy_o (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] wdat, output logic [31:0] rdat, output logic acked);
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wdat;
    acked = 1'b0;
    rdat  = '0;
    for (int i = 0; i < 8 && !acked; i++) begin
      tick();
      if (bus.wbs_ack_o === 1'b1) begin
        acked = 1'b1;
        rdat  = bus.wbs_dat_o;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] wdat);
    logic [31:0] d;
    logic        a;
    xfer(1'b1, adr, 4'hF, wdat, d, a);
    check($sformatf("wr_ack_%0h", adr), 32'(a), 32'd1);
  endtask

  task automatic rd(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    logic        a;
    xfer(1'b0, adr, 4'hF, 32'd0, d, a);
    check({name, "_ack"}, 32'(a), 32'd1);
    check(name, d, exp);
  endtask

  // Samples every clock of one frame against the ideal waveform.
  task automatic capture(input string name, input logic [7:0] b, input int div,
                         input bit back2back, output int lat);
    logic [11:0] eb;
    int          nb;
    int          errs;
    int          first_bad;
    eb     = '0;
    eb[0]  = 1'b0;
    eb[8:1] = b;
    nb     = 9;
`ifdef UART_TX_PARITY_EN
    eb[9] = ^b;
    nb    = 10;
`endif
    eb[nb] = 1'b1;
    nb++;
    tick();
    lat = 1;
    if (!back2back) begin
      while (tx === 1'b1 && lat < 100) begin
        tick();
        lat++;
      end
    end
    check({name, "_start"}, 32'(tx), 32'd0);
    if (tx === 1'b0) begin
      errs = 0;
      first_bad = -1;
      for (int k = 0; k < nb; k++) begin
        for (int c = 0; c < div; c++) begin
          if (k != 0 || c != 0) tick();
          if (tx !== eb[k]) begin
            errs++;
            if (first_bad < 0) first_bad = k;
          end
        end
      end
      if (errs != 0) $display("  %s first wrong bit position %0d", name, first_bad);
      check({name, "_bad_samples"}, 32'(errs), 32'd0);
      check({name, "_busy_in_stop"}, 32'(busy), 32'd1);
    end
  endtask

  // After the last stop sample: line stays idle and busy drops.
  task automatic tail(input string name);
    int lows;
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
      if (i == 1) check({name, "_busy_drop"}, 32'(busy), 32'd0);
    end
    check({name, "_idle_low_samples"}, 32'(lows), 32'd0);
  endtask

  initial begin
    vec_t        vecs[20];
    logic [31:0] d;
    logic        a;
    int          lat;
    int          lows;

    n_checks = 0;
    n_pass   = 0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = '0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    wb_rst_n = 1'b0;

    vecs[0]  = '{1'b0, A_ST,  4'hF, 32'h0,          1'b1, 32'h1 | PAR};
    vecs[1]  = '{1'b0, A_DIV, 4'hF, 32'h0,          1'b1, 32'd4167};
    vecs[2]  = '{1'b0, A_TX,  4'hF, 32'h0,          1'b1, 32'h0};
    vecs[3]  = '{1'b0, A_UNM, 4'hF, 32'h0,          1'b1, 32'h0};
    vecs[4]  = '{1'b1, A_UNM, 4'hF, 32'hFFFF_FFFF,  1'b1, 32'h0};
    vecs[5]  = '{1'b0, A_ST,  4'hF, 32'h0,          1'b1, 32'h1 | PAR};
    vecs[6]  = '{1'b1, A_DIV, 4'hF, 32'd2,          1'b1, 32'h0};
    vecs[7]  = '{1'b0, A_DIV, 4'hF, 32'h0,          1'b1, 32'd4};
    vecs[8]  = '{1'b1, A_DIV, 4'hF, 32'h0000_ABCD,  1'b1, 32'h0};
    vecs[9]  = '{1'b0, A_DIV, 4'hF, 32'h0,          1'b1, 32'h0000_ABCD};
    vecs[10] = '{1'b1, A_DIV, 4'h1, 32'h0000_1234,  1'b1, 32'h0};
    vecs[11] = '{1'b0, A_DIV, 4'hF, 32'h0,          1'b1, 32'h0000_AB34};
    vecs[12] = '{1'b1, A_DIV, 4'h2, 32'h0000_5600,  1'b1, 32'h0};
    vecs[13] = '{1'b0, A_DIV, 4'hF, 32'h0,          1'b1, 32'h0000_5634};
    vecs[14] = '{1'b1, A_DIV, 4'h3, 32'h0000_0003,  1'b1, 32'h0};
    vecs[15] = '{1'b0, A_DIV, 4'hF, 32'h0,          1'b1, 32'd4};
    vecs[16] = '{1'b0, A_OUT, 4'hF, 32'h0,          1'b0, 32'h0};
    vecs[17] = '{1'b1, A_TX,  4'h0, 32'h0000_0099,  1'b1, 32'h0};
    vecs[18] = '{1'b0, A_ST,  4'hF, 32'h0,          1'b1, 32'h1 | PAR};
    vecs[19] = '{1'b1, A_ST,  4'hF, 32'h0000_0008,  1'b1, 32'h0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_during", 32'(tx), 32'd1);
    check("rst_busy_during", 32'(busy), 32'd0);
    wb_rst_n = 1'b1;
    tick();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
    check("rst_dat", bus.wbs_dat_o, 32'd0);

    // Ack is a single cycle and read data returns to zero with it.
    xfer(1'b0, A_DIV, 4'hF, 32'd0, d, a);
    tick();
    check("ack_single_cycle", 32'(bus.wbs_ack_o), 32'd0);
    check("dat_zero_after_ack", bus.wbs_dat_o, 32'd0);

    // Register access table.
    for (int i = 0; i < 20; i++) begin
      xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wdat, d, a);
      check($sformatf("vec%0d_ack", i), 32'(a), 32'(vecs[i].exp_ack));
      if (!vecs[i].we) check($sformatf("vec%0d_data", i), d, vecs[i].exp_rdat);
    end

    // Single 0x55 frame at divisor 8.
    wr(A_DIV, 32'd8);
    wr(A_TX, 32'h55);
    capture("t2_0x55", 8'h55, 8, 1'b0, lat);
    check("t2_start_within_2", 32'(lat <= 2), 32'd1);
    tail("t2");

    // Overflow: the primer byte occupies the shifter so nine writes see the whole FIFO.
    wr(A_DIV, 32'd4);
    fork
      begin
        wr(A_TX, 32'hFF);
        for (int i = 0; i < 9; i++) wr(A_TX, 32'(i));
        rd("t3_status_full", A_ST, 32'h8E | PAR);
      end
      begin
        capture("t3_primer", 8'hFF, 4, 1'b0, lat);
        for (int i = 0; i < 8; i++) capture($sformatf("t3_byte%0d", i), 8'(i), 4, 1'b1, lat);
      end
    join
    tail("t3");
    rd("t3_status_ovf", A_ST, 32'h09 | PAR);
    wr(A_ST, 32'h8);
    rd("t3_status_clr", A_ST, 32'h01 | PAR);

    // Reset in the middle of data bit 3 of 0xA5 with another byte queued.
    wr(A_DIV, 32'd8);
    fork
      begin
        wr(A_TX, 32'hA5);
        wr(A_TX, 32'h3C);
      end
      begin
        tick();
        lat = 1;
        while (tx === 1'b1 && lat < 100) begin
          tick();
          lat++;
        end
        check("t4_start", 32'(tx), 32'd0);
        repeat (4 * 8 + 2) tick();
        check("t4_bit3_low", 32'(tx), 32'd0);
      end
    join
    #2 wb_rst_n = 1'b0;
    #1;
    check("t4_async_tx", 32'(tx), 32'd1);
    check("t4_async_busy", 32'(busy), 32'd0);
    tick();
    tick();
    wb_rst_n = 1'b1;
    rd("t4_status", A_ST, 32'h01 | PAR);
    rd("t4_clkdiv", A_DIV, 32'd4167);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    check("t4_no_frame_after_reset", 32'(lows), 32'd0);

    // CLKDIV written mid-frame applies from the next frame.
    wr(A_DIV, 32'd4);
    fork
      begin
        wr(A_TX, 32'h3C);
        wr(A_TX, 32'hC3);
        wr(A_DIV, 32'd16);
      end
      begin
        capture("t5_old_div", 8'h3C, 4, 1'b0, lat);
        capture("t5_new_div", 8'hC3, 16, 1'b1, lat);
      end
    join
    tail("t5");
    rd("t5_clkdiv", A_DIV, 32'd16);

    // Parity-sensitive byte pair (odd and even popcount).
    wr(A_DIV, 32'd4);
    fork
      begin
        wr(A_TX, 32'h07);
        wr(A_TX, 32'h03);
      end
      begin
        capture("t6_0x07", 8'h07, 4, 1'b0, lat);
        capture("t6_0x03", 8'h03, 4, 1'b1, lat);
      end
    join
    tail("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
